hier_a_st_sequencer: RTL and testbench

- Shares one narrow element channel among NUM_REQ requesters. Each requester submits a full aSt record (hierInclude_package).
- Round-robin arbitration picks one record and captures it. The block then emits the record as an ASIZE2-beat burst, one aBiggerT element of variablea2 per beat, with the scalar header fields alongside.
- Sits between aSt producers and the single downstream element consumer.

---
 rtl/hier_a_st_sequencer.sv | 129 ++++++++++++
 tb/tb_hier_a_st_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hier_a_st_sequencer.sv
// Round-robin sequencer: grants one aSt record and streams variablea2 as a burst.
// Optional macro HIER_A_SEQ_BACKTOBACK_EN re-arbitrates on the last beat (no idle bubble).
package hierInclude_package;
    localparam int ASIZE2 = 11;
    typedef logic [10:0] aBiggerT;
    typedef struct packed {
        logic [7:0]               variablea;
        logic [2:0]               another;
        logic [7:0]               yetAnother;
        aBiggerT [ASIZE2-1:0]     variablea2;
    } aSt;
endpackage

module hier_a_st_sequencer
    import hierInclude_package::*;
#(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = $bits(aSt),
    parameter int IDX_W   = $clog2(ASIZE2),
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*REQ_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [10:0]              out_elem,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_first,
    output logic                     out_last,
    output logic [18:0]              out_hdr,
    output logic [SRC_W-1:0]         out_src,
    output logic                     busy
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t           state, state_nxt;
    aSt               hold;
    logic [IDX_W-1:0] idx;
    logic [SRC_W-1:0] src, rr_ptr, src_nxt;
    logic [SRC_W-1:0] arb_base, cand, gnt_idx;
    logic             found, arb_en, fire;
    logic             beat_hs, idx_last;

    assign idx_last = (idx == IDX_W'(ASIZE2-1));
    assign beat_hs  = (state == BURST) && out_ready;
    assign src_nxt  = (src == SRC_W'(NUM_REQ-1)) ? '0 : src + 1'b1;

`ifdef HIER_A_SEQ_BACKTOBACK_EN
    // the pointer for the overlapping grant is the one the finishing burst installs
    assign arb_en   = (state == IDLE) || (beat_hs && idx_last);
    assign arb_base = (state == IDLE) ? rr_ptr : src_nxt;
`else
    assign arb_en   = (state == IDLE);
    assign arb_base = rr_ptr;
`endif

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = SRC_W'((int'(arb_base) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign fire = arb_en && found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (fire) state_nxt = BURST;
            BURST: if (beat_hs && idx_last)
                       state_nxt = fire ? BURST : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold   <= '0;
            src    <= '0;
            idx    <= '0;
            rr_ptr <= '0;
        end else begin
            if (fire) begin
                hold <= aSt'(req_data[gnt_idx*REQ_W +: REQ_W]);
                src  <= gnt_idx;
                idx  <= '0;
            end else if (beat_hs && !idx_last) begin
                idx <= idx + 1'b1;
            end
            if (beat_hs && idx_last) rr_ptr <= src_nxt;
        end
    end

    always_comb begin
        req_ready = fire ? (NUM_REQ'(1) << gnt_idx) : '0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_elem  = '0;
        out_idx   = '0;
        out_first = 1'b0;
        out_last  = 1'b0;
        out_hdr   = '0;
        out_src   = '0;
        if (state == BURST) begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_elem  = hold.variablea2[idx];
            out_idx   = idx;
            out_first = (idx == '0);
            out_last  = idx_last;
            out_hdr   = {hold.variablea, hold.another, hold.yetAnother};
            out_src   = src;
        end
    end
endmodule

// File: tb/tb_hier_a_st_sequencer.sv
// Directed bench for hier_a_st_sequencer: vector table plus multi-cycle sequences.
// Build with HIER_A_SEQ_BACKTOBACK_EN to check the back-to-back variant.
module tb_hier_a_st_sequencer;
    localparam int N  = 4;
    localparam int RW = 140;
`ifdef HIER_A_SEQ_BACKTOBACK_EN
    localparam int PERIOD = 11;
`else
    localparam int PERIOD = 12;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*RW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_ready;
    logic [10:0]     out_elem;
    logic [3:0]      out_idx;
    logic            out_first;
    logic            out_last;
    logic [18:0]     out_hdr;
    logic [1:0]      out_src;
    logic            busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hier_a_st_sequencer #(.NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_elem(out_elem), .out_idx(out_idx),
        .out_first(out_first), .out_last(out_last),
        .out_hdr(out_hdr), .out_src(out_src), .busy(busy)
    );

    typedef struct {
        logic        rdy;
        logic        v;
        logic [3:0]  idx;
        logic [10:0] elem;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk(input logic [7:0] va,
        input logic [2:0] an, input logic [7:0] ya,
        input logic [10:0] base, input logic [10:0] step);
        logic [RW-1:0] r;
        r[139:121] = {va, an, ya};
        for (int i = 0; i < 11; i++) r[i*11 +: 11] = base + 11'(i) * step;
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_first(input int exp_src, input string nm);
        bit seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk); #1;
            if (out_valid && out_first) seen = 1;
        end
        chk({nm, " first seen"}, 32'(seen), 1);
        if (seen) chk({nm, " src"}, 32'(out_src), exp_src);
    endtask

    task automatic wait_last(input string nm);
        bit seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk); #1;
            if (out_valid && out_last) seen = 1;
        end
        chk({nm, " last seen"}, 32'(seen), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [18:0] hdr;
        int cnt;
        int srcs [5];
        int cycs [5];
        int cyc;
        bit hit;

        for (int k = 0; k < 15; k++) begin
            tbl[k].rdy  = !(k >= 5 && k <= 7);
            tbl[k].v    = (k < 14);
            tbl[k].idx  = (k <= 5) ? 4'(k) : (k <= 8) ? 4'd5 : 4'(k - 3);
            tbl[k].elem = 11'h400 + 11'(tbl[k].idx) * 11'd3;
        end

        // reset state
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst req_ready", 32'(req_ready), 0);
        chk("rst out_hdr", 32'(out_hdr), 0);
        chk("rst out_elem", 32'(out_elem), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single record from requester 1
        @(negedge clk);
        req_data[1*RW +: RW] = mk(8'h55, 3'h3, 8'hA5, 11'd1, 11'd1);
        req_valid = 4'b0010;
        out_ready = 1'b1;
        #1;
        chk("single grant", 32'(req_ready), 32'b0010);
        chk("single pre valid", 32'(out_valid), 0);
        hdr = {8'h55, 3'h3, 8'hA5};
        for (int b = 0; b < 11; b++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            chk("single valid", 32'(out_valid), 1);
            chk("single idx", 32'(out_idx), b);
            chk("single elem", 32'(out_elem), b + 1);
            chk("single first", 32'(out_first), (b == 0));
            chk("single last", 32'(out_last), (b == 10));
            chk("single hdr", 32'(out_hdr), 32'(hdr));
            chk("single src", 32'(out_src), 1);
            chk("single ready low", 32'(req_ready), 0);
        end
        @(negedge clk); #1;
        chk("single idle valid", 32'(out_valid), 0);
        chk("single idle busy", 32'(busy), 0);

        // backpressure at idx 5, requester 2 (pointer now 2)
        @(negedge clk);
        req_data[2*RW +: RW] = mk(8'h12, 3'h5, 8'h34, 11'h400, 11'd3);
        req_valid = 4'b0100;
        #1;
        chk("bp grant", 32'(req_ready), 32'b0100);
        hdr = {8'h12, 3'h5, 8'h34};
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            req_valid = '0;
            out_ready = tbl[k].rdy;
            #1;
            chk("bp valid", 32'(out_valid), 32'(tbl[k].v));
            if (tbl[k].v) begin
                chk("bp idx", 32'(out_idx), 32'(tbl[k].idx));
                chk("bp elem", 32'(out_elem), 32'(tbl[k].elem));
                chk("bp hdr", 32'(out_hdr), 32'(hdr));
                chk("bp last", 32'(out_last), (tbl[k].idx == 4'd10));
            end
        end
        out_ready = 1'b1;

        // round-robin with all requesters valid
        do_reset();
        for (int i = 0; i < N; i++)
            req_data[i*RW +: RW] = mk(8'(i), 3'(i), 8'(i), 11'(i * 16), 11'd1);
        req_valid = 4'b1111;
        cnt = 0;
        cyc = 0;
        for (int n = 0; n < 80 && cnt < 5; n++) begin
            @(negedge clk); #1;
            cyc++;
            if (out_valid && out_first) begin
                srcs[cnt] = int'(out_src);
                cycs[cnt] = cyc;
                cnt++;
            end
        end
        chk("rr burst count", 32'(cnt), 5);
        for (int j = 0; j < cnt; j++) chk("rr order", 32'(srcs[j]), j % 4);
        for (int j = 1; j < cnt; j++)
            chk("rr period", 32'(cycs[j] - cycs[j-1]), PERIOD);
        req_valid = '0;
        wait_last("rr drain");

        // pointer wrap: last grant 3, then 0 and 2 valid
        do_reset();
        req_valid = 4'b1000;
        wait_first(3, "wrap r3");
        req_valid = 4'b0101;
        wait_last("wrap r3");
        wait_first(0, "wrap r0");
        wait_last("wrap r0");
        wait_first(2, "wrap r2");
        req_valid = '0;
        wait_last("wrap r2");

        // reset mid-burst: leave pointer at 1, start requester 2, abort at idx 4
        req_valid = 4'b0001;
        wait_first(0, "mid pre");
        req_valid = '0;
        wait_last("mid pre");
        req_valid = 4'b0100;
        wait_first(2, "mid r2");
        req_valid = '0;
        hit = out_valid && out_idx == 4'd4;
        for (int n = 0; n < 20 && !hit; n++) begin
            @(negedge clk); #1;
            hit = out_valid && out_idx == 4'd4;
        end
        chk("mid reached idx4", 32'(hit), 1);
        rst_n = 1'b0;
        #1;
        chk("mid rst valid", 32'(out_valid), 0);
        chk("mid rst busy", 32'(busy), 0);
        chk("mid rst ready", 32'(req_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 4'b0011;
        wait_first(0, "mid after rst");
        req_valid = '0;
        wait_last("mid after rst");

        // back-to-back handoff from requester 0 to requester 1
        do_reset();
        req_valid = 4'b0011;
        wait_first(0, "b2b r0");
        hit = out_valid && out_idx == 4'd10;
        for (int n = 0; n < 20 && !hit; n++) begin
            @(negedge clk); #1;
            hit = out_valid && out_idx == 4'd10;
        end
        chk("b2b reached idx10", 32'(hit), 1);
`ifdef HIER_A_SEQ_BACKTOBACK_EN
        chk("b2b ready on last", 32'(req_ready), 32'b0010);
        @(negedge clk); #1;
        chk("b2b next valid", 32'(out_valid), 1);
        chk("b2b next busy", 32'(busy), 1);
        chk("b2b next first", 32'(out_first), 1);
        chk("b2b next src", 32'(out_src), 1);
`else
        chk("b2b ready on last", 32'(req_ready), 0);
        @(negedge clk); #1;
        chk("b2b idle valid", 32'(out_valid), 0);
        chk("b2b idle busy", 32'(busy), 0);
        chk("b2b idle grant", 32'(req_ready), 32'b0010);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
